i281_code_memory: RTL and testbench

Parametrised, run-time-loadable instruction memory for the i281 CPU. It replaces fixed, hard-wired program ROMs.
- The CPU fetches combinationally through a single read port.
- A byte-stream loader fills the memory using a valid/ready handshake. Each image is framed by a start pulse and closed by a mod-256 checksum byte.
- The CPU is held off while a load is in progress or after a failed load.

---
 rtl/i281_code_memory_if.sv | 29 ++
 rtl/i281_code_memory.sv | 129 ++++++++++++
 tb/tb_i281_code_memory.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i281_code_memory_if.sv
// i281 code memory bus: CPU fetch port plus byte-stream loader handshake.
// master = CPU/loader side, slave = memory side.
interface i281_code_memory_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] fetch_addr;
  logic [WIDTH-1:0]  fetch_data;
  logic              load_start;
  logic [7:0]        load_data;
  logic              load_valid;
  logic              load_ready;
  logic              load_done;
  logic              load_error;
  logic              cpu_hold;
  logic [ADDR_W:0]   word_count;

  modport master (
    output fetch_addr, load_start, load_data, load_valid,
    input  fetch_data, load_ready, load_done, load_error,
    input  cpu_hold, word_count
  );

  modport slave (
    input  fetch_addr, load_start, load_data, load_valid,
    output fetch_data, load_ready, load_done, load_error,
    output cpu_hold, word_count
  );
endinterface

// File: rtl/i281_code_memory.sv
// i281 run-time loadable instruction memory: combinational fetch port,
// checksummed MSB-first byte loader; ports clk, rst, bus (slave modport).
module i281_code_memory #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic               clk,
  input logic               rst,
  i281_code_memory_if.slave bus
);
  localparam int BPW  = WIDTH / 8;
  localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  asm_q;
  logic [WIDTH-1:0]  asm_n;
  logic [ADDR_W-1:0] ptr;
  logic [BI_W-1:0]   byte_idx;
  logic [7:0]        sum;
  logic [ADDR_W:0]   wcount;
  logic              done_q;
  logic              err_q;

  logic xfer;
  logic last_byte;
  logic last_word;
  logic clr;
  logic take;
  logic done_n;
  logic err_set;

  assign xfer      = bus.load_valid && (state != IDLE);
  assign last_byte = (byte_idx == BI_W'(BPW - 1));
  assign last_word = (ptr == ADDR_W'(DEPTH - 1));
  assign asm_n     = (asm_q << 8) | WIDTH'(bus.load_data);

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    take    = 1'b0;
    done_n  = 1'b0;
    err_set = 1'b0;
    // A start pulse wins over any byte offered in the same cycle.
    if (bus.load_start) begin
      state_n = RECV;
      clr     = 1'b1;
    end else begin
      unique case (state)
        RECV: begin
          take = xfer;
          if (xfer && last_byte && last_word)
            state_n = CHECK;
        end
        CHECK: begin
          if (xfer) begin
            state_n = IDLE;
            if (bus.load_data == sum)
              done_n = 1'b1;
            else
              err_set = 1'b1;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      asm_q    <= '0;
      ptr      <= '0;
      byte_idx <= '0;
      sum      <= '0;
      wcount   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
      if (clr) begin
        asm_q    <= '0;
        ptr      <= '0;
        byte_idx <= '0;
        sum      <= '0;
        wcount   <= '0;
        err_q    <= 1'b0;
      end else begin
        if (err_set)
          err_q <= 1'b1;
        if (take) begin
          asm_q <= asm_n;
          sum   <= sum + bus.load_data;
          if (last_byte) begin
            mem[ptr] <= asm_n;
            wcount   <= wcount + 1'b1;
            byte_idx <= '0;
            if (!last_word)
              ptr <= ptr + 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.fetch_data = '0;
    if ({1'b0, bus.fetch_addr} < (ADDR_W+1)'(DEPTH))
      bus.fetch_data = mem[bus.fetch_addr];
  end

  assign bus.load_ready = (state != IDLE);
  assign bus.load_done  = done_q;
  assign bus.load_error = err_q;
  assign bus.cpu_hold   = (state != IDLE) || err_q;
  assign bus.word_count = wcount;
endmodule

// File: tb/tb_i281_code_memory.sv
// Bench for i281_code_memory: 16x16 and 24x10 instances, random and
// directed images, scoreboarded done/error events.
module tb_i281_code_memory;
  typedef logic [7:0] img_t [32];
  typedef logic [7:0] img2_t [30];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i281_code_memory_if #(.WIDTH(16), .ADDR_W(4)) bus ();
  i281_code_memory_if #(.WIDTH(24), .ADDR_W(4)) bus2 ();

  i281_code_memory #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  i281_code_memory #(.WIDTH(24), .DEPTH(10), .ADDR_W(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] m1 [16];
  logic [23:0] m2 [10];
  logic [1:0]  q1 [$];
  logic [1:0]  q2 [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected response", nm);
  endtask

  // Event monitors: {done, error-rise} is compared against the queue.
  logic e1 = 1'b0;
  logic e2 = 1'b0;
  always @(negedge clk) begin : mon1
    logic [1:0] ev;
    if (rst) e1 = 1'b0;
    else begin
      ev = {bus.load_done, bus.load_error & ~e1};
      if (ev != 2'b00) begin
        if (q1.size() == 0) fail_now("event1_unexpected");
        else chk("event1", 32'(ev), 32'(q1.pop_front()));
      end
      e1 = bus.load_error;
    end
  end

  always @(negedge clk) begin : mon2
    logic [1:0] ev;
    if (rst) e2 = 1'b0;
    else begin
      ev = {bus2.load_done, bus2.load_error & ~e2};
      if (ev != 2'b00) begin
        if (q2.size() == 0) fail_now("event2_unexpected");
        else chk("event2", 32'(ev), 32'(q2.pop_front()));
      end
      e2 = bus2.load_error;
    end
  end

  function automatic logic [7:0] csum(img_t im);
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(im[i]);
    return 8'(s % 256);
  endfunction

  task automatic sweep1(string nm);
    for (int a = 0; a < 16; a++) begin
      bus.fetch_addr = 4'(a);
      #1;
      chk(nm, 32'(bus.fetch_data), 32'(m1[a]));
    end
  endtask

  task automatic start1(input bit junk);
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_valid = junk;
    bus.load_data  = 8'hAA;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    chk("start_hold", 32'(bus.cpu_hold), 32'd1);
    chk("start_err", 32'(bus.load_error), 32'd0);
    chk("start_wc", 32'(bus.word_count), 32'd0);
  endtask

  task automatic send1(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(posedge clk);
    #1;
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    while (!bus.load_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) fail_now("ready1_timeout");
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'($urandom);
  endtask

  function automatic int gapof(int mode);
    if (mode == 1) return 2;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  // Send the first n bytes of an image; model words land as pairs complete.
  task automatic body1(img_t im, int n, int mode);
    for (int i = 0; i < n; i++) begin
      send1(im[i], gapof(mode));
      if (i % 2 == 1) m1[i/2] = {im[i-1], im[i]};
    end
  endtask

  task automatic full1(img_t im, bit bad, int mode);
    logic [7:0] c;
    start1(1'b0);
    body1(im, 32, mode);
    chk("check_wc", 32'(bus.word_count), 32'd16);
    c = csum(im) + (bad ? 8'd1 : 8'd0);
    q1.push_back(bad ? 2'b01 : 2'b10);
    send1(c, gapof(mode));
    chk("post_hold", 32'(bus.cpu_hold), bad ? 32'd1 : 32'd0);
    chk("post_err", 32'(bus.load_error), bad ? 32'd1 : 32'd0);
    chk("post_wc", 32'(bus.word_count), 32'd16);
  endtask

  task automatic send2(input logic [7:0] b);
    int t = 0;
    bus2.load_valid = 1'b1;
    bus2.load_data  = b;
    while (!bus2.load_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) fail_now("ready2_timeout");
    @(posedge clk); #1;
    bus2.load_valid = 1'b0;
  endtask

  img_t good = '{8'hF0, 8'h04, 8'h3C, 8'h08, 8'h7C, 8'h01, 8'hF1, 8'hFE,
                 8'hE0, 8'h11, 8'h38, 8'h79, 8'hA8, 8'h04, 8'h38, 8'h54,
                 8'hA8, 8'h05, 8'h38, 8'h5E, 8'hA8, 8'h06, 8'h00, 8'h00,
                 8'hE0, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    img_t  ra;
    img2_t r2;
    int    s2;

    rst = 1'b1;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_data  = '0;
    bus.load_valid = 1'b0;
    bus2.fetch_addr = '0;
    bus2.load_start = 1'b0;
    bus2.load_data  = '0;
    bus2.load_valid = 1'b0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    for (int i = 0; i < 10; i++) m2[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    sweep1("reset_fetch");
    chk("reset_hold", 32'(bus.cpu_hold), 32'd0);
    chk("reset_ready", 32'(bus.load_ready), 32'd0);
    chk("reset_wc", 32'(bus.word_count), 32'd0);
    chk("reset_done", 32'(bus.load_done), 32'd0);

    full1(good, 1'b0, 0);
    sweep1("good_fetch");
    bus.fetch_addr = 4'd0; #1;
    chk("word0", 32'(bus.fetch_data), 32'h0000F004);
    bus.fetch_addr = 4'd12; #1;
    chk("word12", 32'(bus.fetch_data), 32'h0000E0FE);

    // Bytes offered while idle must be ignored.
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 32'(bus.load_ready), 32'd0);
    chk("idle_wc", 32'(bus.word_count), 32'd16);
    chk("idle_hold", 32'(bus.cpu_hold), 32'd0);
    bus.load_valid = 1'b0;

    full1(good, 1'b1, 0);
    sweep1("bad_fetch");
    full1(good, 1'b0, 0);

    for (int i = 0; i < 32; i++) ra[i] = 8'($urandom);
    full1(ra, 1'b0, 1);
    sweep1("gap_fetch");
    full1(good, 1'b0, 2);
    sweep1("rgap_fetch");

    // Restart after 5 words; byte offered with the start pulse is dropped.
    for (int i = 0; i < 32; i++) ra[i] = 8'($urandom);
    start1(1'b0);
    body1(ra, 10, 2);
    chk("partial_wc", 32'(bus.word_count), 32'd5);
    sweep1("partial_fetch");
    for (int i = 0; i < 32; i++) ra[i] = 8'($urandom);
    start1(1'b1);
    body1(ra, 32, 2);
    q1.push_back(2'b10);
    send1(csum(ra), 0);
    chk("restart_wc", 32'(bus.word_count), 32'd16);
    chk("restart_hold", 32'(bus.cpu_hold), 32'd0);
    sweep1("restart_fetch");

    // Reset in the middle of a load.
    start1(1'b0);
    body1(ra, 10, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    sweep1("midrst_fetch");
    chk("midrst_hold", 32'(bus.cpu_hold), 32'd0);
    chk("midrst_ready", 32'(bus.load_ready), 32'd0);
    chk("midrst_wc", 32'(bus.word_count), 32'd0);

    // 24-bit, 10-deep instance.
    r2[0] = 8'h12; r2[1] = 8'h34; r2[2] = 8'h56;
    for (int i = 3; i < 30; i++) r2[i] = 8'($urandom);
    s2 = 0;
    for (int i = 0; i < 30; i++) s2 += int'(r2[i]);
    @(posedge clk); #1;
    bus2.load_start = 1'b1;
    @(posedge clk); #1;
    bus2.load_start = 1'b0;
    chk("w24_start_hold", 32'(bus2.cpu_hold), 32'd1);
    for (int i = 0; i < 30; i++) begin
      send2(r2[i]);
      if (i % 3 == 2) m2[i/3] = {r2[i-2], r2[i-1], r2[i]};
      if (i == 28)
        chk("w24_wc29", 32'(bus2.word_count), 32'd9);
    end
    chk("w24_wc30", 32'(bus2.word_count), 32'd10);
    chk("w24_check_ready", 32'(bus2.load_ready), 32'd1);
    chk("w24_check_hold", 32'(bus2.cpu_hold), 32'd1);
    q2.push_back(2'b10);
    send2(8'(s2 % 256));
    chk("w24_hold", 32'(bus2.cpu_hold), 32'd0);
    chk("w24_ready", 32'(bus2.load_ready), 32'd0);
    for (int a = 0; a < 16; a++) begin
      bus2.fetch_addr = 4'(a);
      #1;
      chk("w24_fetch", 32'(bus2.fetch_data), a < 10 ? 32'(m2[a]) : 32'd0);
    end
    bus2.fetch_addr = 4'd0; #1;
    chk("w24_word0", 32'(bus2.fetch_data), 32'h00123456);

    repeat (3) @(posedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end
endmodule
